// File: rtl/csr_trap_seq.sv
// Machine-mode CSR port sequencer. It serialises Zicsr ops, trap/irq entry and mret
// onto the single CSR-file port, and it produces the PC redirect for traps and mret.
module csr_trap_seq #(
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000_000B,
  parameter int unsigned MIE_IRQ_BIT = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_valid,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] csr_wdata,
  input  logic        irq,
  input  logic [31:0] irq_pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_write_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_in,
  input  logic [31:0] csr_out,
  input  logic [31:0] csr_mstatus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned OPW  = 2;

  localparam logic [AW-1:0] ADDR_MSTATUS  = AW'(12'h300);
  localparam logic [AW-1:0] ADDR_MIE      = AW'(12'h304);
  localparam logic [AW-1:0] ADDR_MTVEC    = AW'(12'h305);
  localparam logic [AW-1:0] ADDR_MSCRATCH = AW'(12'h340);
  localparam logic [AW-1:0] ADDR_MEPC     = AW'(12'h341);
  localparam logic [AW-1:0] ADDR_MCAUSE   = AW'(12'h342);
  localparam logic [AW-1:0] ADDR_MHARTID  = AW'(12'hF14);

  localparam logic [OPW-1:0] OP_NONE = OPW'(2'b00);
  localparam logic [OPW-1:0] OP_RW   = OPW'(2'b01);
  localparam logic [OPW-1:0] OP_RS   = OPW'(2'b10);
  localparam logic [OPW-1:0] OP_RC   = OPW'(2'b11);

  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_MPP_LO = 11;
  localparam int unsigned MS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_STATUS = 3'd3,
    T_VEC    = 3'd4,
    M_STATUS = 3'd5,
    M_EPC    = 3'd6,
    C_EXEC   = 3'd7
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] cause_q, pc_q, wdata_q;
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   addr_q;

  logic            acc_trap, acc_irq, acc_csr, irq_pend;
  logic            addr_known, wr_intent, op_illegal;
  logic [XLEN-1:0] csr_new, ms_trap, ms_mret;

  logic            done_next, illegal_next, redirect_next;
  logic [XLEN-1:0] rdata_next, redirect_pc_next;

  // Zicsr decode and new-value computation on the latched operands
  always_comb begin
    addr_known = (addr_q == ADDR_MSTATUS) || (addr_q == ADDR_MIE) ||
                 (addr_q == ADDR_MTVEC)   || (addr_q == ADDR_MSCRATCH) ||
                 (addr_q == ADDR_MEPC)    || (addr_q == ADDR_MCAUSE) ||
                 (addr_q == ADDR_MHARTID);
    wr_intent  = (op_q == OP_RW) || (wdata_q != '0);
    op_illegal = !addr_known || (op_q == OP_NONE) ||
                 (wr_intent && (addr_q[AW-1:AW-2] == 2'b11));
    case (op_q)
      OP_RW:   csr_new = wdata_q;
      OP_RS:   csr_new = csr_out | wdata_q;
      OP_RC:   csr_new = csr_out & ~wdata_q;
      default: csr_new = csr_out;
    endcase
  end

  // mstatus images for trap entry and mret; machine mode is the only privilege level
  always_comb begin
    ms_trap                        = csr_mstatus;
    ms_trap[MS_MPIE]               = csr_mstatus[MS_MIE];
    ms_trap[MS_MIE]                = 1'b0;
    ms_trap[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
    ms_mret                        = csr_mstatus;
    ms_mret[MS_MIE]                = csr_mstatus[MS_MPIE];
    ms_mret[MS_MPIE]               = 1'b1;
    ms_mret[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
  end

  always_comb begin
    state_next       = state;
    busy             = (state != IDLE);
    csr_write_en     = 1'b0;
    csr_addr         = ADDR_MIE;
    csr_in           = '0;
    irq_pend         = 1'b0;
    acc_trap         = 1'b0;
    acc_irq          = 1'b0;
    acc_csr          = 1'b0;
    done_next        = 1'b0;
    illegal_next     = 1'b0;
    redirect_next    = 1'b0;
    rdata_next       = '0;
    redirect_pc_next = redirect_pc;

    case (state)
      IDLE: begin
        // csr_addr parks on mie so csr_out gives the interrupt enable here
        irq_pend = irq & csr_mstatus[MS_MIE] & csr_out[MIE_IRQ_BIT];
        if (trap_valid) begin
          acc_trap   = 1'b1;
          state_next = T_EPC;
        end else if (mret_valid) begin
          state_next = M_STATUS;
        end else if (csr_valid) begin
          acc_csr    = 1'b1;
          state_next = C_EXEC;
        end else if (irq_pend) begin
          acc_irq    = 1'b1;
          state_next = T_EPC;
        end
      end
      T_EPC: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MEPC;
        csr_in       = {pc_q[XLEN-1:2], 2'b00};
        state_next   = T_CAUSE;
      end
      T_CAUSE: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MCAUSE;
        csr_in       = cause_q;
        state_next   = T_STATUS;
      end
      T_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_in       = ms_trap;
        state_next   = T_VEC;
      end
      T_VEC: begin
        csr_addr         = ADDR_MTVEC;
        redirect_pc_next = {csr_out[XLEN-1:2], 2'b00};
        done_next        = 1'b1;
        redirect_next    = 1'b1;
        state_next       = IDLE;
      end
      M_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_in       = ms_mret;
        state_next   = M_EPC;
      end
      M_EPC: begin
        csr_addr         = ADDR_MEPC;
        redirect_pc_next = csr_out;
        done_next        = 1'b1;
        redirect_next    = 1'b1;
        state_next       = IDLE;
      end
      C_EXEC: begin
        csr_addr     = addr_q;
        csr_in       = csr_new;
        csr_write_en = !op_illegal && wr_intent;
        rdata_next   = op_illegal ? '0 : csr_out;
        illegal_next = op_illegal;
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      done           <= 1'b0;
      illegal        <= 1'b0;
      redirect_valid <= 1'b0;
      rdata          <= '0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      done           <= done_next;
      illegal        <= illegal_next;
      redirect_valid <= redirect_next;
      rdata          <= rdata_next;
      redirect_pc    <= redirect_pc_next;
    end
  end

  // Operands are captured only on acceptance and then held for the whole sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      pc_q    <= '0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (acc_trap) begin
        cause_q <= trap_cause;
        pc_q    <= trap_pc;
      end else if (acc_irq) begin
        cause_q <= IRQ_CAUSE;
        pc_q    <= irq_pc;
      end
      if (acc_csr) begin
        op_q    <= csr_op;
        addr_q  <= csr_addr_in;
        wdata_q <= csr_wdata;
      end
    end
  end

endmodule
